// File: rtl/ndp_axis_tx_packer.sv
// ---------------------------------------------------------------------------
// ndp_axis_tx_packer
// Transmit end of the NDP result path. Takes WIDTH-bit result elements over
// a valid/ready handshake, packs element pairs into AXIS_WIDTH-bit beats and
// streams them out through a first-word-fall-through beat FIFO, using tlast
// to mark the end of each result vector.
//
// Ports
//   axi_aclk       in   single clock, rising edge
//   axi_areset     in   synchronous active-high reset
//   in_data        in   result element
//   in_valid       in   in_data valid
//   in_last        in   element ends the current result vector
//   in_ready       out  element accepted this cycle when in_valid is high
//   m_axis_tdata   out  output beat (FIFO head, zero when empty)
//   m_axis_tvalid  out  FIFO holds at least one beat
//   m_axis_tlast   out  head beat ends a packet
//   m_axis_tready  in   downstream accepts the head beat
//   pkt_count      out  transferred tlast beats (wraps)
//   beat_count     out  transferred beats (wraps)
// ---------------------------------------------------------------------------
module ndp_axis_tx_packer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

    // Pack state and lower-lane holding register
    pack_state_t             r_state;
    pack_state_t             w_state_nxt;
    logic [WIDTH-1:0]        r_hold;
    logic [WIDTH-1:0]        w_hold_nxt;

    // FIFO storage and bookkeeping
    logic [AXIS_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
    logic                    r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_count;

    logic [CNT_WIDTH-1:0]    r_pkt_count;
    logic [CNT_WIDTH-1:0]    r_beat_count;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_push;
    logic [AXIS_WIDTH-1:0]   w_push_data;
    logic                    w_push_last;
    logic                    w_fifo_valid;
    logic                    w_pop;

    // Ready depends only on reset and the registered FIFO level, so a pop in
    // the same cycle never opens the input early.
    assign w_in_ready   = !axi_areset && (r_count != LVL_FULL);
    assign w_accept     = in_valid && w_in_ready;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && m_axis_tready;

    // Pack FSM: state register
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state <= ST_EMPTY;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Pack FSM: next state and beat push. Every accept in HALF, and a
    // last-flagged accept in EMPTY, produces a beat; the FIFO always has
    // room because accept implies not full.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_push      = 1'b0;
        w_push_data = '0;
        w_push_last = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    if (in_last) begin
                        // Odd-length tail: upper lane zero-padded
                        w_push      = 1'b1;
                        w_push_data = AXIS_WIDTH'({{WIDTH{1'b0}}, in_data});
                        w_push_last = 1'b1;
                    end else begin
                        w_hold_nxt  = in_data;
                        w_state_nxt = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_data = AXIS_WIDTH'({in_data, r_hold});
                    w_push_last = in_last;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // FIFO storage: no reset needed, empty FIFO masks the outputs
    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

    // FIFO pointers and level; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transfer status counters
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_beat_count <= '0;
            r_pkt_count  <= '0;
        end else if (w_pop) begin
            r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            if (r_mem_last[r_rd_ptr]) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    // Head of FIFO drives the stream; held until popped
    assign in_ready      = w_in_ready;
    assign m_axis_tvalid = w_fifo_valid;
    assign m_axis_tdata  = w_fifo_valid ? r_mem_data[r_rd_ptr] : '0;
    assign m_axis_tlast  = w_fifo_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign pkt_count     = r_pkt_count;
    assign beat_count    = r_beat_count;

endmodule
